// File: rtl/tile_router_if.sv
// Stream and row-output bundle between the tile reader environment and the tile router.
// The master drives incoming words and row pops; the slave (router) drives backpressure and row heads.
interface tile_router_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int ROWS       = 4
) ();
  logic                       i_data_valid;
  logic [ADDR_WIDTH-1:0]      i_data_addr;
  logic [DATA_WIDTH-1:0]      i_data;
  logic                       o_ready;
  logic [ROWS-1:0]            o_row_valid;
  logic [ROWS*DATA_WIDTH-1:0] o_row_data;
  logic [ROWS*ADDR_WIDTH-1:0] o_row_addr;
  logic [ROWS-1:0]            i_row_ready;

  modport master (
    output i_data_valid, i_data_addr, i_data, i_row_ready,
    input  o_ready, o_row_valid, o_row_data, o_row_addr
  );

  modport slave (
    input  i_data_valid, i_data_addr, i_data, i_row_ready,
    output o_ready, o_row_valid, o_row_data, o_row_addr
  );
endinterface

// File: rtl/tile_router.sv
// Routes buffered tile words round-robin into per-row show-ahead FIFOs feeding the PE-array rows,
// with registered backpressure, end-of-tile detection and a done pulse.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for i_start; no pushes, o_ready low
//  S_ROUTE | pushing valid words into FIFO[row_ptr], counting words
//  S_DRAIN | all words counted; waiting for every row FIFO to empty
//  S_DONE  | single-cycle o_done pulse, then back to S_IDLE
module tile_router #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic                i_reg_clear,
  input  logic                i_start,
  input  logic [ADDR_WIDTH:0] i_word_count,
  tile_router_if.slave        io_bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic                o_stray
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(ROWS);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_WIDTH:0] r_target;
  logic [ADDR_WIDTH:0] r_count;
  logic [RW-1:0]       r_row_ptr;
  logic                r_ready;
  logic [EW-1:0]       r_mem  [ROWS][FIFO_DEPTH];
  logic [PW:0]         r_wptr [ROWS];
  logic [PW:0]         r_rptr [ROWS];

  logic [PW:0]                w_used     [ROWS];
  logic [PW:0]                w_used_nxt [ROWS];
  logic [ROWS-1:0]            w_valid, w_full, w_pop, w_push;
  logic                       w_in_route, w_hit_full, w_all_empty, w_room_nxt, w_last;
  logic [ADDR_WIDTH:0]        w_count_inc;
  logic [EW-1:0]              w_head;
  logic [ROWS*DATA_WIDTH-1:0] w_row_data;
  logic [ROWS*ADDR_WIDTH-1:0] w_row_addr;

  always_comb begin
    w_in_route  = (r_state == S_ROUTE) && io_bus.i_data_valid;
    w_hit_full  = 1'b0;
    w_all_empty = 1'b1;
    w_room_nxt  = 1'b1;
    w_row_data  = '0;
    w_row_addr  = '0;
    w_head      = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_used[r]  = r_wptr[r] - r_rptr[r];
      w_valid[r] = (w_used[r] != '0);
      w_full[r]  = (w_used[r] == (PW+1)'(FIFO_DEPTH));
      // an empty FIFO ignores i_row_ready
      w_pop[r]   = w_valid[r] & io_bus.i_row_ready[r];
      w_push[r]  = w_in_route && (r_row_ptr == RW'(r)) && (!w_full[r] || w_pop[r]);
      if (w_in_route && (r_row_ptr == RW'(r)) && w_full[r] && !w_pop[r])
        w_hit_full = 1'b1;
      w_used_nxt[r] = w_used[r] + (PW+1)'(w_push[r]) - (PW+1)'(w_pop[r]);
      if (w_valid[r])
        w_all_empty = 1'b0;
      if (w_used_nxt[r] > (PW+1)'(FIFO_DEPTH - 2))
        w_room_nxt = 1'b0;
      w_head = r_mem[r][r_rptr[r][PW-1:0]];
      if (w_valid[r]) begin
        w_row_data[r*DATA_WIDTH +: DATA_WIDTH] = w_head[DATA_WIDTH-1:0];
        w_row_addr[r*ADDR_WIDTH +: ADDR_WIDTH] = w_head[EW-1:DATA_WIDTH];
      end
    end
    w_count_inc = r_count + (ADDR_WIDTH+1)'(1);
    w_last      = (w_count_inc == r_target);
  end

  assign io_bus.o_row_valid = w_valid;
  assign io_bus.o_row_data  = w_row_data;
  assign io_bus.o_row_addr  = w_row_addr;
  assign io_bus.o_ready     = r_ready;

  always_ff @(posedge i_clk) begin
    for (int r = 0; r < ROWS; r++)
      if (w_push[r])
        r_mem[r][r_wptr[r][PW-1:0]] <= {io_bus.i_data_addr, io_bus.i_data};
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int r = 0; r < ROWS; r++) begin
        r_wptr[r] <= '0;
        r_rptr[r] <= '0;
      end
    end else if (i_reg_clear) begin
      for (int r = 0; r < ROWS; r++) begin
        r_wptr[r] <= '0;
        r_rptr[r] <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (w_push[r]) r_wptr[r] <= r_wptr[r] + (PW+1)'(1);
        if (w_pop[r])  r_rptr[r] <= r_rptr[r] + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state    <= S_IDLE;
      r_target   <= '0;
      r_count    <= '0;
      r_row_ptr  <= '0;
      r_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      o_stray    <= 1'b0;
    end else if (i_reg_clear) begin
      r_state    <= S_IDLE;
      r_target   <= '0;
      r_count    <= '0;
      r_row_ptr  <= '0;
      r_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      o_stray    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (io_bus.i_data_valid && (r_state != S_ROUTE)) o_stray <= 1'b1;
      if (w_hit_full) o_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          // an accepted start clears the sticky flags, overriding the stray set above
          if (i_start) begin
            r_target   <= i_word_count;
            r_count    <= '0;
            r_row_ptr  <= '0;
            o_overflow <= 1'b0;
            o_stray    <= 1'b0;
            o_busy     <= 1'b1;
            if (i_word_count == '0) begin
              r_state <= S_DRAIN;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_ROUTE;
              r_ready <= w_room_nxt;
            end
          end
        end
        S_ROUTE: begin
          r_ready <= w_room_nxt;
          if (io_bus.i_data_valid) begin
            r_count   <= w_count_inc;
            r_row_ptr <= r_row_ptr + RW'(1);
            if (w_last) begin
              r_state <= S_DRAIN;
              r_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (w_all_empty) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tile_router.sv
// Randomized self-checking bench for tile_router against a queue-based behavioural model
// of the routing rules; every cycle compares flags, backpressure and each row head.
module tb_tile_router;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int ROWS = 4;
  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_ROUTE = 1, M_DRAIN = 2, M_DONE = 3;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          reg_clear = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, overflow, stray;

  tile_router_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROWS(ROWS)) bus ();

  tile_router #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(reg_clear), .i_start(start),
    .i_word_count(word_count), .io_bus(bus.slave),
    .o_busy(busy), .o_done(done), .o_overflow(overflow), .o_stray(stray)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic rdy_prev = 1'b0;

  int   m_st, m_target, m_cnt, m_rp;
  bit   m_busy, m_done, m_ready, m_ovf, m_stray;
  ent_t q[ROWS][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) q[r].delete();
    m_st = M_IDLE; m_target = 0; m_cnt = 0; m_rp = 0;
    m_busy = 0; m_done = 0; m_ready = 0; m_ovf = 0; m_stray = 0;
  endtask

  task automatic model_edge();
    int   sz[ROWS];
    bit   popv[ROWS];
    bit   all_empty, do_push;
    int   nst, prow;
    ent_t e;
    if (reg_clear) begin
      model_reset();
      return;
    end
    all_empty = 1; do_push = 0; prow = 0;
    for (int r = 0; r < ROWS; r++) begin
      sz[r] = q[r].size();
      popv[r] = (sz[r] > 0) && bus.i_row_ready[r];
      if (sz[r] > 0) all_empty = 0;
    end
    nst = m_st;
    m_done = 0;
    if (bus.i_data_valid && m_st != M_ROUTE) m_stray = 1;
    case (m_st)
      M_IDLE: if (start) begin
        m_target = int'(word_count); m_cnt = 0; m_rp = 0; m_ovf = 0; m_stray = 0;
        nst = (word_count == 0) ? M_DRAIN : M_ROUTE;
      end
      M_ROUTE: if (bus.i_data_valid) begin
        if (sz[m_rp] < DEPTH || popv[m_rp]) begin
          do_push = 1; prow = m_rp;
        end else m_ovf = 1;
        m_cnt++;
        m_rp = (m_rp + 1) % ROWS;
        if (m_cnt == m_target) nst = M_DRAIN;
      end
      M_DRAIN: if (all_empty) begin
        nst = M_DONE; m_done = 1;
      end
      default: nst = M_IDLE;
    endcase
    for (int r = 0; r < ROWS; r++) if (popv[r]) void'(q[r].pop_front());
    if (do_push) begin
      e.a = bus.i_data_addr; e.d = bus.i_data;
      q[prow].push_back(e);
    end
    m_st = nst;
    m_busy = (nst != M_IDLE);
    m_ready = (nst == M_ROUTE);
    for (int r = 0; r < ROWS; r++) if (DEPTH - q[r].size() < 2) m_ready = 0;
  endtask

  task automatic check_outputs();
    bit ev;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("ready", bus.o_ready, m_ready);
    chk("overflow", overflow, m_ovf);
    chk("stray", stray, m_stray);
    for (int r = 0; r < ROWS; r++) begin
      ev = q[r].size() > 0;
      chk("row_valid", bus.o_row_valid[r], ev);
      if (ev) begin
        chk("row_data", bus.o_row_data[r*DW +: DW], q[r][0].d);
        chk("row_addr", bus.o_row_addr[r*AW +: AW], q[r][0].a);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (done) done_cnt++;
    rdy_prev = bus.o_ready;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input bit v, input int a);
    bus.i_data_valid = v;
    bus.i_data_addr = a[AW-1:0];
    bus.i_data = {$urandom, $urandom};
  endtask

  task automatic start_tile(input int wc);
    word_count = wc[AW:0];
    start = 1'b1;
    drive_word(0, 0);
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int d0 = done_cnt;
    for (int k = 0; k < bound && done_cnt == d0; k++) cycle();
    chk(tag, done_cnt - d0, 1);
  endtask

  initial begin
    int sent, d0;
    bit saw_low;
    bus.i_row_ready = '0;
    drive_word(0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    chk("reset_row_valid", bus.o_row_valid, 0);

    // round-robin distribution, all rows draining
    bus.i_row_ready = '1;
    start_tile(8);
    for (int i = 0; i < 8; i++) begin
      drive_word(1, i);
      cycle();
    end
    drive_word(0, 0);
    wait_done(50, "t2_done");
    repeat (3) cycle();

    // empty tile: IDLE, DRAIN, DONE
    d0 = done_cnt;
    start_tile(0);
    cycle();
    cycle();
    chk("t3_done_at_2", done_cnt - d0, 1);
    cycle();

    // backpressure honoured with stalled rows
    bus.i_row_ready = '0;
    start_tile(40);
    sent = 0;
    saw_low = 0;
    for (int k = 0; k < 400 && m_st != M_IDLE; k++) begin
      if (k == 60) bus.i_row_ready = '1;
      if (rdy_prev && sent < 40) begin
        drive_word(1, sent);
        sent++;
      end else drive_word(0, 0);
      cycle();
      if (!rdy_prev && sent > 0 && sent < 40) saw_low = 1;
    end
    drive_word(0, 0);
    chk("t4_ready_dropped", saw_low, 1);
    chk("t4_no_overflow", overflow, 0);
    chk("t4_sent", sent, 40);
    cycle();

    // overflow on stalled row 0, o_ready ignored
    bus.i_row_ready = 4'b1110;
    start_tile(36);
    for (int i = 0; i < 36; i++) begin
      drive_word(1, i);
      cycle();
    end
    drive_word(0, 0);
    repeat (5) cycle();
    chk("t5_overflow", overflow, 1);
    bus.i_row_ready = '1;
    wait_done(50, "t5_done");
    cycle();
    chk("t5_overflow_sticky", overflow, 1);

    // synchronous clear in DRAIN, then stray word in IDLE
    bus.i_row_ready = '0;
    start_tile(4);
    for (int i = 0; i < 4; i++) begin
      drive_word(1, i);
      cycle();
    end
    drive_word(0, 0);
    repeat (3) cycle();
    d0 = done_cnt;
    reg_clear = 1'b1;
    cycle();
    reg_clear = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_fifos_empty", bus.o_row_valid, 0);
    repeat (4) cycle();
    chk("t6_no_done", done_cnt - d0, 0);
    drive_word(1, 9);
    cycle();
    drive_word(0, 0);
    cycle();
    chk("t6_stray", stray, 1);

    // asynchronous reset mid-ROUTE with 3 words buffered
    start_tile(10);
    for (int i = 0; i < 3; i++) begin
      drive_word(1, i);
      cycle();
    end
    drive_word(0, 0);
    #2;
    nrst = 1'b0;
    #1;
    chk("t1_row_valid", bus.o_row_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_ready", bus.o_ready, 0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // random tiles, back-to-back restarts, random pops and ignored starts
    for (int t = 0; t < 8; t++) begin
      start_tile($urandom_range(0, 20));
      d0 = done_cnt;
      for (int k = 0; k < 600 && done_cnt == d0; k++) begin
        drive_word($urandom_range(0, 3) != 0, $urandom_range(0, 255));
        bus.i_row_ready = 4'($urandom);
        start = ($urandom_range(0, 15) == 0);
        cycle();
      end
      start = 1'b0;
      drive_word(0, 0);
      chk("rand_done", done_cnt - d0, 1);
    end
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
